fir_mac_sequencer: RTL and testbench

Time-multiplexed controller for the team's 10-tap FIR datapath. It accepts 16-bit samples over a valid/ready handshake and keeps them in a circular delay line. For each sample it sequences one shared multiplier-accumulator across all taps, then presents a saturated 16-bit result over a second valid/ready handshake. A coefficient write port reloads tap weights between samples. The block replaces the fully parallel multiply-add with a single MAC.

---
 rtl/fir_mac_sequencer.sv | 112 +++++++++++
 tb/tb_fir_mac_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequenced FIR: one shared multiply-accumulate walks all taps of a circular
// delay line per accepted sample, then holds a saturated result until taken.
module fir_mac_sequencer #(
    parameter int TAPS      = 10,
    parameter int OUT_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             y,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [15:0]             coef_data,
    output logic                    coef_busy,
    output logic                    busy
);
    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = 32 + AW;
    localparam logic [AW:0]   TAPS_L = (AW+1)'(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t            state_q;
    logic [15:0]       delay_q [TAPS];
    logic [15:0]       coef_q  [TAPS];
    logic [AW-1:0]     wp_q, cur_q, k_q;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [15:0]       y_q, y_d;
    logic              in_ready_q, out_valid_q, busy_q;

    logic [AW:0]       diff;
    logic [AW:0]       rd_full;
    logic [AW-1:0]     rd_idx;
    logic [31:0]       prod;
    logic [ACCW-1:0]   shifted;

    // Tap k reads the sample k positions older than the newest one, modulo TAPS.
    always_comb begin
        diff    = {1'b0, cur_q} + TAPS_L - {1'b0, k_q};
        rd_full = (diff >= TAPS_L) ? diff - TAPS_L : diff;
        rd_idx  = rd_full[AW-1:0];
        prod    = coef_q[k_q] * delay_q[rd_idx];
        acc_d   = acc_q + {{AW{1'b0}}, prod};
        shifted = acc_d >> OUT_SHIFT;
        y_d     = (|shifted[ACCW-1:16]) ? 16'hFFFF : shifted[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            cur_q       <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= 16'd1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (coef_we && ({1'b0, coef_addr} < TAPS_L))
                        coef_q[coef_addr] <= coef_data;
                    if (in_valid) begin
                        delay_q[wp_q] <= x;
                        cur_q         <= wp_q;
                        wp_q          <= (wp_q == LAST) ? '0 : wp_q + 1'b1;
                        acc_q         <= '0;
                        k_q           <= '0;
                        state_q       <= MAC;
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    // Result is registered on the final tap so OUT presents it immediately.
                    if (k_q == LAST) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        y_q         <= y_d;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign coef_busy = ~in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: reference model fills a scoreboard,
// results are popped and compared as each output handshake appears.
module tb_fir_mac_sequencer;
    localparam int TAPS = 10;
    localparam int AW   = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [15:0]   x = '0;
    logic          out_ready = 1'b0;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [15:0]   coef_data = '0;

    logic          in_ready, out_valid, coef_busy, busy;
    logic [15:0]   y;
    logic          in_ready1, out_valid1, coef_busy1, busy1;
    logic [15:0]   y1;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    logic [15:0] hist  [TAPS];
    logic [15:0] mcoef [TAPS];

    always #5 clk = ~clk;

    fir_mac_sequencer #(.TAPS(TAPS), .OUT_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy), .busy(busy));

    fir_mac_sequencer #(.TAPS(TAPS), .OUT_SHIFT(1)) dut_sh (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .x(x),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy1), .busy(busy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            hist[i]  = '0;
            mcoef[i] = 16'd1;
        end
    endtask

    // hist[0] is always the newest sample.
    task automatic model_push(input logic [15:0] v);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
    endtask

    function automatic logic [15:0] model_y(input int sh);
        longint unsigned s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(mcoef[i]) * longint'(hist[i]);
        s = s >> sh;
        return (s > 64'hFFFF) ? 16'hFFFF : s[15:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp0_q.delete();
        exp1_q.delete();
    endtask

    task automatic wr_coef(input logic [AW-1:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        if (int'(a) < TAPS) mcoef[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // we_acc: coefficient write alongside the accepted sample; we_mac: ignored write in MAC
    task automatic send(input logic [15:0] xv, input bit we_acc, input bit we_mac, input int hold);
        int n;
        logic [15:0] e0, e1;
        n = 0;
        while (!in_ready && n < 64) begin @(negedge clk); n++; end
        chk("in_ready_wait", in_ready, 1);
        x = xv; in_valid = 1'b1;
        if (we_acc) begin
            coef_we = 1'b1; coef_addr = '0; coef_data = 16'd5; mcoef[0] = 16'd5;
        end
        model_push(xv);
        exp0_q.push_back(model_y(0));
        exp1_q.push_back(model_y(1));
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        chk("busy_mac", busy, 1);
        chk("coef_busy_mac", coef_busy, 1);
        chk("in_ready_mac", in_ready, 0);
        n = 1;
        while (!out_valid && n < 64) begin
            if (we_mac && n == 3) begin
                coef_we = 1'b1; coef_addr = AW'(1); coef_data = 16'd9;
            end else coef_we = 1'b0;
            @(negedge clk);
            n++;
        end
        coef_we = 1'b0;
        chk("latency", n, TAPS + 1);
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        chk("y", y, e0);
        chk("y_shift1", y1, e1);
        chk("out_valid_shift1", out_valid1, 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; x = 16'h1234;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_y_stable", y, e0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_coef_busy", coef_busy, 0);
        chk("rst_busy", busy, 0);

        // Impulse with default coefficients
        send(16'd100, 0, 0, 0);
        for (int i = 0; i < 11; i++) send(16'd0, 0, 0, 0);

        // Step, with backpressure on the third result and delay-line wrap at the end
        for (int i = 0; i < 12; i++) send(16'd5, 0, 0, (i == 2) ? 5 : 0);

        // Saturation, both shift settings
        do_reset();
        send(16'hFFFF, 0, 0, 0);
        send(16'hFFFF, 0, 0, 0);

        // Coefficient load; out-of-range write ignored; MAC-time write ignored
        do_reset();
        wr_coef(AW'(0), 16'd2);
        wr_coef(AW'(1), 16'd3);
        for (int i = 2; i < TAPS; i++) wr_coef(AW'(i), 16'd0);
        wr_coef(AW'(12), 16'd77);
        send(16'd10, 0, 0, 0);
        send(16'd20, 0, 1, 0);
        send(16'd1, 1, 0, 0);

        // Reset at MAC cycle 4 discards the result and restores defaults
        while (!in_ready) @(negedge clk);
        x = 16'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        send(16'd7, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
